alu_arbiter: RTL and testbench

Round-robin arbiter that shares one combinational `alu` instance between two requesters (e.g. the integer pipe and the address/vector-scalar helper). Each requester presents operands and a 4-bit ALU control code with a valid/ready handshake. The winner's operation goes through the ALU in the grant cycle. Result and flags are captured into a per-requester response register, which is held until that requester accepts it.

---
 rtl/alu_arb_pkg.sv | 27 ++
 rtl/alu_arb_rsp_slot.sv | 58 +++++
 rtl/alu_arbiter.sv | 86 ++++++++
 tb/tb_alu_arbiter.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester ALU arbiter.
// Slot state, ALU code/flag types and the round-robin pick.
package alu_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef logic [3:0] alu_ctrl_t;
  typedef logic [3:0] alu_flags_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  // Winner index among two eligible requesters.
  // The side opposite last grant wins a contest.
  function automatic logic rr_winner(
    input logic [1:0] elig,
    input logic       last
  );
    if (elig == 2'b11) begin
      return ~last;
    end
    return elig[1];
  endfunction

endpackage

// File: rtl/alu_arb_rsp_slot.sv
// One response slot: EMPTY/FULL FSM plus the
// captured ALU result and flags for one requester.
module alu_arb_rsp_slot
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             grant,
  input  logic             rsp_ready,
  input  logic [WIDTH-1:0] result,
  input  alu_flags_t       flags,
  output logic             can_accept,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_result,
  output alu_flags_t       rsp_flags
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    alu_flags_t       flags;
  } rsp_t;

  slot_state_e state;
  rsp_t        rsp_q;

  // Slot FSM; a grant while FULL is a drain-and-refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      rsp_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (grant) begin
            state <= FULL;
            rsp_q <= {result, flags};
          end
        end
        FULL: begin
          if (grant) begin
            rsp_q <= {result, flags};
          end else if (rsp_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign rsp_valid  = (state == FULL);
  assign can_accept = (state == EMPTY) | rsp_ready;
  assign rsp_result = rsp_q.result;
  assign rsp_flags  = rsp_q.flags;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one external combinational ALU
// between two requesters, with per-requester response slots.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_op1,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_op2,
  input  logic [NUM_REQ-1:0][3:0]       req_ctrl,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [NUM_REQ-1:0][WIDTH-1:0] rsp_result,
  output logic [NUM_REQ-1:0][3:0]       rsp_flags,
  output logic [WIDTH-1:0]              alu_op1,
  output logic [WIDTH-1:0]              alu_op2,
  output logic [3:0]                    alu_control,
  input  logic [WIDTH-1:0]              alu_result,
  input  logic [3:0]                    alu_flags
);

  import alu_arb_pkg::*;

  logic [NUM_REQ-1:0] can_acc;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt;
  logic               win;
  logic               last_grant;

  assign elig = req_valid & can_acc & {NUM_REQ{~reset}};
  assign win  = rr_winner(elig, last_grant);
  assign gnt  = (elig == '0) ? 2'b00 :
                (win ? 2'b10 : 2'b01);

  assign req_ready = gnt;

  // Steer the winner's operation onto the ALU port.
  always_comb begin
    alu_op1     = '0;
    alu_op2     = '0;
    alu_control = 4'h0;
    unique case (1'b1)
      gnt[0]: begin
        alu_op1     = req_op1[0];
        alu_op2     = req_op2[0];
        alu_control = req_ctrl[0];
      end
      gnt[1]: begin
        alu_op1     = req_op1[1];
        alu_op2     = req_op2[1];
        alu_control = req_ctrl[1];
      end
      default: ;
    endcase
  end

  // Round-robin pointer follows every grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (gnt != '0) begin
      last_grant <= gnt[1];
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    alu_arb_rsp_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .grant      (gnt[i]),
      .rsp_ready  (rsp_ready[i]),
      .result     (alu_result),
      .flags      (alu_flags),
      .can_accept (can_acc[i]),
      .rsp_valid  (rsp_valid[i]),
      .rsp_result (rsp_result[i]),
      .rsp_flags  (rsp_flags[i])
    );
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a
// behavioural ALU and response-slot reference model.
module tb_alu_arbiter;

  localparam int W = 32;

  logic              clk;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][W-1:0] req_op1;
  logic [1:0][W-1:0] req_op2;
  logic [1:0][3:0]   req_ctrl;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [1:0][W-1:0] rsp_result;
  logic [1:0][3:0]   rsp_flags;
  logic [W-1:0]      alu_op1;
  logic [W-1:0]      alu_op2;
  logic [3:0]        alu_control;
  logic [W-1:0]      alu_result;
  logic [3:0]        alu_flags;

  int total;
  int bad;

  bit         m_valid [2];
  logic [W-1:0] m_res [2];
  logic [3:0] m_flg [2];
  int         m_last;

  // {flags, result}; flags = {N, Z, C, V}
  function automatic logic [W+3:0] alu_ref(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [3:0]   c
  );
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         cy;
    logic         v;
    cy = 1'b0;
    v  = 1'b0;
    case (c)
      4'h0: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[W-1:0];
        cy = s[W];
        v  = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'h1: begin
        r  = a - b;
        cy = (a >= b);
        v  = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = a << b[4:0];
      4'h6: r = a >> b[4:0];
      4'h7: r = $signed(a) >>> b[4:0];
      4'h8: r = {31'd0, $signed(a) < $signed(b)};
      4'h9: r = {31'd0, a < b};
      default: r = '0;
    endcase
    return {r[W-1], (r == '0), cy, v, r};
  endfunction

  assign {alu_flags, alu_result} =
    alu_ref(alu_op1, alu_op2, alu_control);

  alu_arbiter #(
    .WIDTH   (W),
    .NUM_REQ (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .req_ctrl    (req_ctrl),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int exp_grant();
    bit e0;
    bit e1;
    if (reset) return -1;
    e0 = req_valid[0] && (!m_valid[0] || rsp_ready[0]);
    e1 = req_valid[1] && (!m_valid[1] || rsp_ready[1]);
    if (e0 && e1) return 1 - m_last;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] exp_ready();
    int g;
    g = exp_grant();
    if (g < 0) return 2'b00;
    return (g == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_step();
    int g;
    logic [W+3:0] o;
    g = exp_grant();
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_valid[i] = 1'b0;
        m_res[i]   = '0;
        m_flg[i]   = '0;
      end
      m_last = 1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (g == i) begin
          o = alu_ref(req_op1[i], req_op2[i], req_ctrl[i]);
          m_valid[i] = 1'b1;
          m_res[i]   = o[W-1:0];
          m_flg[i]   = o[W+3:W];
        end else if (m_valid[i] && rsp_ready[i]) begin
          m_valid[i] = 1'b0;
        end
      end
      if (g >= 0) m_last = g;
    end
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (req_ready !== 2'b00) begin
        bad++;
        $display("FAIL reset_req_ready got=%b want=00", req_ready);
      end
      total++;
      if (rsp_valid !== 2'b00 || rsp_result !== '0 ||
          rsp_flags !== '0) begin
        bad++;
        $display("FAIL reset_rsp got v=%b r=%h f=%h want zeros",
                 rsp_valid, rsp_result, rsp_flags);
      end
      advance();
    end
    reset     = 1'b0;
    req_valid = 2'b00;
  endtask

  task automatic test_single();
    logic [W-1:0] cap_r;
    logic [3:0]   cap_f;
    req_op1[0]  = 7;
    req_op2[0]  = 1;
    req_ctrl[0] = 4'h0;
    req_valid   = 2'b01;
    rsp_ready   = 2'b01;
    @(negedge clk);
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL single_ready got=%b want=01", req_ready);
    end
    total++;
    if (alu_op1 !== 7 || alu_op2 !== 1 || alu_control !== 4'h0) begin
      bad++;
      $display("FAIL single_alu_port got=%0d/%0d/%h want=7/1/0",
               alu_op1, alu_op2, alu_control);
    end
    cap_r = alu_result;
    cap_f = alu_flags;
    advance();
    req_valid = 2'b00;
    @(negedge clk);
    total++;
    if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== cap_r ||
        rsp_flags[0] !== cap_f || cap_r !== 8) begin
      bad++;
      $display("FAIL single_rsp got v=%b r=%0d f=%h want v=1 r=8 f=%h",
               rsp_valid[0], rsp_result[0], rsp_flags[0], cap_f);
    end
    advance();
  endtask

  task automatic test_contention();
    reset = 1'b1;
    @(negedge clk);
    advance();
    reset       = 1'b0;
    req_op1[0]  = 5;
    req_op2[0]  = 5;
    req_op1[1]  = -3;
    req_op2[1]  = 7;
    req_ctrl    = '0;
    req_valid   = 2'b11;
    rsp_ready   = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        bad++;
        $display("FAIL contention_grant k=%0d got=%b", k, req_ready);
      end
      for (int i = 0; i < 2; i++) begin
        total++;
        if (rsp_valid[i] !== m_valid[i] ||
            (m_valid[i] && rsp_result[i] !== ((i == 0) ? 10 : 4))) begin
          bad++;
          $display("FAIL contention_rsp%0d got v=%b r=%0d want v=%b",
                   i, rsp_valid[i], rsp_result[i], m_valid[i]);
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    reset = 1'b1;
    @(negedge clk);
    advance();
    reset      = 1'b0;
    req_op1[0] = 1;
    req_op2[0] = -1;
    req_ctrl   = '0;
    req_op1[1] = 20;
    req_op2[1] = 2;
    req_valid  = 2'b11;
    rsp_ready  = 2'b10;
    @(negedge clk);
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL bp_first_grant got=%b want=01", req_ready);
    end
    advance();
    for (int k = 0; k < 4; k++) begin
      req_op2[1] = k;
      @(negedge clk);
      total++;
      if (req_ready !== 2'b10) begin
        bad++;
        $display("FAIL bp_hold_grant k=%0d got=%b want=10", k, req_ready);
      end
      total++;
      if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== 0 ||
          rsp_flags[0] !== 4'b0110) begin
        bad++;
        $display("FAIL bp_hold_rsp got v=%b r=%0d f=%b want 1/0/0110",
                 rsp_valid[0], rsp_result[0], rsp_flags[0]);
      end
      advance();
    end
    req_op1[0] = 5;
    rsp_ready  = 2'b11;
    @(negedge clk);
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL bp_refill_grant got=%b want=01", req_ready);
    end
    advance();
    rsp_ready = 2'b00;
    req_valid = 2'b00;
    @(negedge clk);
    total++;
    if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== 4) begin
      bad++;
      $display("FAIL bp_refill_rsp got v=%b r=%0d want 1/4",
               rsp_valid[0], rsp_result[0]);
    end
    advance();
  endtask

  task automatic test_sweep();
    rsp_ready = 2'b11;
    req_valid = 2'b10;
    for (int k = 0; k <= 10; k++) begin
      req_op1[1]  = 3;
      req_op2[1]  = k + 1;
      req_ctrl[1] = 4'(k);
      req_valid   = (k < 10) ? 2'b10 : 2'b00;
      @(negedge clk);
      total++;
      if (req_ready !== exp_ready()) begin
        bad++;
        $display("FAIL sweep_ready k=%0d got=%b want=%b",
                 k, req_ready, exp_ready());
      end
      if (k > 0) begin
        total++;
        if (rsp_valid[1] !== 1'b1 || rsp_result[1] !== m_res[1] ||
            rsp_flags[1] !== m_flg[1]) begin
          bad++;
          $display("FAIL sweep_rsp ctrl=%0d got r=%h f=%h want r=%h f=%h",
                   k - 1, rsp_result[1], rsp_flags[1], m_res[1], m_flg[1]);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    repeat (2) begin
      @(negedge clk);
      advance();
    end
    total++;
    if (rsp_valid !== 2'b11) begin
      bad++;
      $display("FAIL mid_fill got=%b want=11", rsp_valid);
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (req_ready !== 2'b00) begin
        bad++;
        $display("FAIL mid_reset_ready got=%b want=00", req_ready);
      end
      advance();
    end
    total++;
    if (rsp_valid !== 2'b00) begin
      bad++;
      $display("FAIL mid_reset_valid got=%b want=00", rsp_valid);
    end
    reset     = 1'b0;
    rsp_ready = 2'b11;
    @(negedge clk);
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL mid_first_grant got=%b want=01", req_ready);
    end
    advance();
    req_valid = 2'b00;
    @(negedge clk);
    advance();
  endtask

  task automatic test_spurious();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
        bad++;
        $display("FAIL spurious_idle got v=%b rdy=%b want 00/00",
                 rsp_valid, req_ready);
      end
      advance();
    end
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    @(negedge clk);
    advance();
    @(negedge clk);
    total++;
    if (req_ready !== 2'b00) begin
      bad++;
      $display("FAIL spurious_blocked got=%b want=00", req_ready);
    end
    advance();
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    @(negedge clk);
    advance();
    @(negedge clk);
    total++;
    if (rsp_valid !== 2'b00) begin
      bad++;
      $display("FAIL spurious_drop got=%b want=00", rsp_valid);
    end
    advance();
  endtask

  task automatic test_random();
    int g;
    for (int k = 0; k < 400; k++) begin
      reset      = ($urandom_range(0, 49) == 0);
      req_valid  = 2'($urandom);
      rsp_ready  = 2'($urandom);
      req_op1[0] = $urandom;
      req_op2[0] = $urandom;
      req_op1[1] = $urandom;
      req_op2[1] = $urandom;
      req_ctrl[0] = 4'($urandom_range(0, 11));
      req_ctrl[1] = 4'($urandom_range(0, 11));
      @(negedge clk);
      total++;
      if (req_ready !== exp_ready()) begin
        bad++;
        $display("FAIL rand_ready k=%0d got=%b want=%b",
                 k, req_ready, exp_ready());
      end
      g = exp_grant();
      if (g >= 0) begin
        total++;
        if (alu_op1 !== req_op1[g] || alu_op2 !== req_op2[g] ||
            alu_control !== req_ctrl[g]) begin
          bad++;
          $display("FAIL rand_alu_port k=%0d got=%h/%h/%h want req%0d",
                   k, alu_op1, alu_op2, alu_control, g);
        end
      end
      for (int i = 0; i < 2; i++) begin
        total++;
        if (rsp_valid[i] !== m_valid[i] ||
            (m_valid[i] && (rsp_result[i] !== m_res[i] ||
                            rsp_flags[i] !== m_flg[i]))) begin
          bad++;
          $display("FAIL rand_rsp%0d k=%0d got v=%b r=%h f=%h want v=%b r=%h f=%h",
                   i, k, rsp_valid[i], rsp_result[i], rsp_flags[i],
                   m_valid[i], m_res[i], m_flg[i]);
        end
      end
      advance();
    end
    reset = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_op1   = '0;
    req_op2   = '0;
    req_ctrl  = '0;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_res[i]   = '0;
      m_flg[i]   = '0;
    end
    m_last = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_sweep();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
